// File: rtl/axi_iso_pkg.sv
// Shared types for the AXI isolation/drain controller.
package axi_iso_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } iso_state_e;

endpackage

// File: rtl/axi_iso_cnt.sv
// Saturating up/down outstanding-transaction counter.
// A decrement at zero holds the count and raises underflow for that cycle.
module axi_iso_cnt #(
  parameter int W   = 5,
  parameter int MAX = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic zero_o,
  output logic underflow_o
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  assign full_o = (cnt_q == MAX_C);
  assign zero_o = (cnt_q == '0);

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (!full_o) cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i) begin
      if (zero_o) underflow_o = 1'b1;
      else        cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axi_isolate_drain_ctrl.sv
// Handshake gate ahead of the dual-clock slave slice: blocks new AW/AR on request,
// drains in-flight bursts, then isolates the slice and acknowledges.
//
//   state    | meaning
//   NORMAL   | AW/AR/W pass subject to outstanding limits
//   DRAIN    | new AW/AR blocked, owed W beats still pass, waiting for B/R-last
//   ISOLATED | everything gated, isolate_o and isolate_ack_o high
module axi_isolate_drain_ctrl
  import axi_iso_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 16,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic isolate_req_i,
  output logic isolate_o,
  output logic isolate_ack_o,
  output logic err_o,
  input  logic aw_valid_i,
  output logic aw_ready_o,
  output logic aw_valid_o,
  input  logic aw_ready_i,
  input  logic w_valid_i,
  output logic w_ready_o,
  input  logic w_last_i,
  output logic w_valid_o,
  input  logic w_ready_i,
  input  logic ar_valid_i,
  output logic ar_ready_o,
  output logic ar_valid_o,
  input  logic ar_ready_i,
  input  logic r_valid_i,
  input  logic r_ready_i,
  input  logic r_last_i,
  input  logic b_valid_i,
  input  logic b_ready_i
);

  iso_state_e state_q, state_d;
  logic       isolate_q, isolate_d;
  logic       err_q, err_d;

  logic aw_full, aw_zero, aw_uf;
  logic w_full_unused, w_zero, w_uf;
  logic ar_full, ar_zero, ar_uf;
  logic aw_en, w_en, ar_en;
  logic aw_hs, w_last_hs, ar_hs, b_hs, r_last_hs;

  assign aw_en = (state_q == NORMAL) && !aw_full;
  assign ar_en = (state_q == NORMAL) && !ar_full;
  assign w_en  = (state_q != ISOLATED) && !w_zero;

  assign aw_valid_o = aw_valid_i & aw_en;
  assign aw_ready_o = aw_ready_i & aw_en;
  assign w_valid_o  = w_valid_i & w_en;
  assign w_ready_o  = w_ready_i & w_en;
  assign ar_valid_o = ar_valid_i & ar_en;
  assign ar_ready_o = ar_ready_i & ar_en;

  assign aw_hs     = aw_valid_o & aw_ready_i;
  assign ar_hs     = ar_valid_o & ar_ready_i;
  assign w_last_hs = w_valid_o & w_ready_i & w_last_i;
  assign b_hs      = b_valid_i & b_ready_i;
  assign r_last_hs = r_valid_i & r_ready_i & r_last_i;

  // w counter tracks AWs that still owe their data beats
  axi_iso_cnt #(.W(CNT_W), .MAX(MAX_OUTSTANDING)) u_aw_cnt (
    .clk_i, .rst_i, .inc_i(aw_hs), .dec_i(b_hs),
    .full_o(aw_full), .zero_o(aw_zero), .underflow_o(aw_uf)
  );

  axi_iso_cnt #(.W(CNT_W), .MAX(MAX_OUTSTANDING)) u_w_cnt (
    .clk_i, .rst_i, .inc_i(aw_hs), .dec_i(w_last_hs),
    .full_o(w_full_unused), .zero_o(w_zero), .underflow_o(w_uf)
  );

  axi_iso_cnt #(.W(CNT_W), .MAX(MAX_OUTSTANDING)) u_ar_cnt (
    .clk_i, .rst_i, .inc_i(ar_hs), .dec_i(r_last_hs),
    .full_o(ar_full), .zero_o(ar_zero), .underflow_o(ar_uf)
  );

  always_comb begin
    state_d   = state_q;
    isolate_d = isolate_q;
    err_d     = err_q | aw_uf | w_uf | ar_uf;
    unique case (state_q)
      NORMAL: if (isolate_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!isolate_req_i) begin
          state_d = NORMAL;
        end else if (aw_zero && ar_zero) begin
          state_d   = ISOLATED;
          isolate_d = 1'b1;
        end
      end
      ISOLATED: begin
        if (!isolate_req_i) begin
          state_d   = NORMAL;
          isolate_d = 1'b0;
        end
      end
      default: begin
        state_d   = NORMAL;
        isolate_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= NORMAL;
      isolate_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      isolate_q <= isolate_d;
      err_q     <= err_d;
    end
  end

  assign isolate_o     = isolate_q;
  assign isolate_ack_o = (state_q == ISOLATED);
  assign err_o         = err_q;

endmodule

// File: tb/tb_axi_isolate_drain_ctrl.sv
// Bench for axi_isolate_drain_ctrl: vector table, directed corner sequences and
// random traffic checked against an outstanding-count model.
module tb_axi_isolate_drain_ctrl;

  localparam int MAXO = 16;

  localparam logic [12:0] REQ = 13'h1000, AWV = 13'h0800, AWR = 13'h0400;
  localparam logic [12:0] WV  = 13'h0200, WR  = 13'h0100, WL  = 13'h0080;
  localparam logic [12:0] ARV = 13'h0040, ARR = 13'h0020, RV  = 13'h0010;
  localparam logic [12:0] RR  = 13'h0008, RL  = 13'h0004, BV  = 13'h0002, BR = 13'h0001;
  localparam logic [12:0] AW = AWV | AWR, W = WV | WR, WLAST = WV | WR | WL;
  localparam logic [12:0] AR = ARV | ARR, RLAST = RV | RR | RL, B = BV | BR;
  localparam logic [12:0] IDLE = 13'h0000;

  localparam logic [8:0] O_ISO = 9'h100, O_ACK = 9'h080, O_ERR = 9'h040;
  localparam logic [8:0] O_AWV = 9'h020, O_AWR = 9'h010, O_WV = 9'h008, O_WR = 9'h004;
  localparam logic [8:0] O_ARV = 9'h002, O_ARR = 9'h001, O_NONE = 9'h000;

  localparam int M_RUN = 0, M_DRAIN = 1, M_ISO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i = 1'b0, isolate_req_i = 1'b0;
  logic aw_valid_i = 1'b0, aw_ready_i = 1'b0, w_valid_i = 1'b0, w_ready_i = 1'b0, w_last_i = 1'b0;
  logic ar_valid_i = 1'b0, ar_ready_i = 1'b0, r_valid_i = 1'b0, r_ready_i = 1'b0, r_last_i = 1'b0;
  logic b_valid_i = 1'b0, b_ready_i = 1'b0;
  logic isolate_o, isolate_ack_o, err_o;
  logic aw_ready_o, aw_valid_o, w_ready_o, w_valid_o, ar_ready_o, ar_valid_o;

  axi_isolate_drain_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst_i), .isolate_req_i(isolate_req_i),
    .isolate_o(isolate_o), .isolate_ack_o(isolate_ack_o), .err_o(err_o),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i)
  );

  int n_chk = 0, n_pass = 0;

  // Model: mode plus plain integer outstanding counts
  int m_mode = M_RUN, m_aw = 0, m_w = 0, m_ar = 0;
  bit m_err = 1'b0;

  typedef struct {
    logic [12:0] in;
    logic [8:0]  exp;
    string       name;
  } vec_t;

  function automatic bit has(input logic [12:0] v, input logic [12:0] m);
    return (v & m) == m;
  endfunction

  function automatic logic [8:0] dut_out();
    return {isolate_o, isolate_ack_o, err_o, aw_valid_o, aw_ready_o,
            w_valid_o, w_ready_o, ar_valid_o, ar_ready_o};
  endfunction

  function automatic logic [8:0] model_out(input logic [12:0] in);
    bit aw_ok = (m_mode == M_RUN) && (m_aw < MAXO);
    bit ar_ok = (m_mode == M_RUN) && (m_ar < MAXO);
    bit w_ok  = (m_mode != M_ISO) && (m_w > 0);
    logic [8:0] e = O_NONE;
    if (m_mode == M_ISO) e |= O_ISO | O_ACK;
    if (m_err) e |= O_ERR;
    if (aw_ok && has(in, AWV)) e |= O_AWV;
    if (aw_ok && has(in, AWR)) e |= O_AWR;
    if (w_ok && has(in, WV)) e |= O_WV;
    if (w_ok && has(in, WR)) e |= O_WR;
    if (ar_ok && has(in, ARV)) e |= O_ARV;
    if (ar_ok && has(in, ARR)) e |= O_ARR;
    return e;
  endfunction

  task automatic model_commit(input logic [12:0] in);
    int aw_hs = ((m_mode == M_RUN) && (m_aw < MAXO) && has(in, AW)) ? 1 : 0;
    int ar_hs = ((m_mode == M_RUN) && (m_ar < MAXO) && has(in, AR)) ? 1 : 0;
    int w_done = ((m_mode != M_ISO) && (m_w > 0) && has(in, WLAST)) ? 1 : 0;
    int b_done = has(in, B) ? 1 : 0;
    int r_done = has(in, RLAST) ? 1 : 0;
    int n_aw = m_aw + aw_hs - b_done;
    int n_w  = m_w + aw_hs - w_done;
    int n_ar = m_ar + ar_hs - r_done;
    bit req  = has(in, REQ);
    if (n_aw < 0) begin n_aw = 0; m_err = 1'b1; end
    if (n_w < 0)  begin n_w = 0;  m_err = 1'b1; end
    if (n_ar < 0) begin n_ar = 0; m_err = 1'b1; end
    if (m_mode == M_RUN) begin
      if (req) m_mode = M_DRAIN;
    end else if (m_mode == M_DRAIN) begin
      if (!req) m_mode = M_RUN;
      else if (m_aw == 0 && m_ar == 0) m_mode = M_ISO;
    end else begin
      if (!req) m_mode = M_RUN;
    end
    m_aw = n_aw;
    m_w  = n_w;
    m_ar = n_ar;
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic apply(input logic [12:0] in);
    {isolate_req_i, aw_valid_i, aw_ready_i, w_valid_i, w_ready_i, w_last_i,
     ar_valid_i, ar_ready_i, r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i} = in;
  endtask

  // One clock cycle: drive on negedge, sample 1ns later, model advances past the next posedge
  task automatic step(input logic [12:0] in, output logic [8:0] got);
    @(negedge clk);
    apply(in);
    #1;
    got = dut_out();
    check("model", got, model_out(in));
    model_commit(in);
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(IDLE);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i  = 1'b0;
    m_mode = M_RUN;
    m_aw = 0; m_w = 0; m_ar = 0;
    m_err = 1'b0;
  endtask

  initial begin
    vec_t        tbl[10];
    logic [8:0]  got;
    logic [12:0] rin;
    bit          rreq;

    tbl[0] = '{AW | AR | W,    O_AWV | O_AWR | O_ARV | O_ARR, "pass normal"};
    tbl[1] = '{WLAST | RLAST | B, O_WV | O_WR,               "w owed"};
    tbl[2] = '{REQ | AW,       O_AWV | O_AWR,                 "overlap aw"};
    tbl[3] = '{REQ | AW | AR,  O_NONE,                        "drain blocks"};
    tbl[4] = '{REQ | WLAST,    O_WV | O_WR,                   "drain w"};
    tbl[5] = '{REQ | B,        O_NONE,                        "drain b"};
    tbl[6] = '{REQ | AW | W,   O_NONE,                        "drain empty"};
    tbl[7] = '{REQ | AW | W,   O_ISO | O_ACK,                 "isolated"};
    tbl[8] = '{AW,             O_ISO | O_ACK,                 "release"};
    tbl[9] = '{AW,             O_AWV | O_AWR,                 "normal again"};

    do_reset();
    check("reset", dut_out() & (O_ISO | O_ACK | O_ERR), O_NONE);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].in, got);
      check(tbl[i].name, got, tbl[i].exp);
    end

    // idle isolation latency and release
    do_reset();
    step(REQ, got);  check("t1 c0", got & (O_ISO | O_ACK), O_NONE);
    step(REQ, got);  check("t1 c1", got & (O_ISO | O_ACK), O_NONE);
    step(REQ, got);  check("t1 c2", got & (O_ISO | O_ACK), O_ISO | O_ACK);
    step(IDLE, got); check("t1 c3", got & (O_ISO | O_ACK), O_ISO | O_ACK);
    step(IDLE, got); check("t1 release", got & (O_ISO | O_ACK), O_NONE);

    // drain one write burst of 4 beats
    do_reset();
    step(AW, got);
    step(REQ, got);
    step(REQ | AW, got); check("t2 aw blocked", got & (O_AWV | O_AWR), O_NONE);
    for (int k = 0; k < 4; k++) begin
      step(REQ | W | ((k == 3) ? WL : IDLE), got);
      check("t2 w beat", got & (O_WV | O_WR | O_ISO), O_WV | O_WR);
    end
    step(REQ, got);     check("t2 wait b", got & O_ISO, O_NONE);
    step(REQ | B, got); check("t2 b", got & O_ISO, O_NONE);
    step(REQ, got);
    step(REQ, got);     check("t2 isolated", got & (O_ISO | O_ACK), O_ISO | O_ACK);

    // AR outstanding limit
    do_reset();
    for (int k = 0; k < MAXO; k++) begin
      step(AR, got); check("t3 ar fill", got & (O_ARV | O_ARR), O_ARV | O_ARR);
    end
    step(AR, got);         check("t3 ar full", got & (O_ARV | O_ARR), O_NONE);
    step(AR | RLAST, got); check("t3 ar full r", got & (O_ARV | O_ARR), O_NONE);
    step(AR, got);         check("t3 ar reopen", got & (O_ARV | O_ARR), O_ARV | O_ARR);

    // B with nothing outstanding
    do_reset();
    step(B, got);    check("t4 err pre", got & O_ERR, O_NONE);
    step(IDLE, got); check("t4 err set", got & O_ERR, O_ERR);
    step(REQ, got);
    step(REQ, got);
    step(REQ, got);  check("t4 err sticky aw0", got & (O_ERR | O_ISO), O_ERR | O_ISO);

    // aborted drain
    do_reset();
    step(AR, got);
    step(AR, got);
    for (int k = 0; k < 3; k++) begin
      step(REQ, got); check("t5 no iso", got & O_ISO, O_NONE);
    end
    step(AR, got); check("t5 abort cycle", got & O_ARR, O_NONE);
    step(AR, got); check("t5 ar reenabled", got & (O_ARV | O_ARR | O_ISO), O_ARV | O_ARR);

    // simultaneous inc/dec, then reset mid-drain
    do_reset();
    step(AW, got);
    step(AW | B, got);  check("t6 aw+b", got & (O_AWR | O_ERR), O_AWR);
    step(REQ, got);
    step(REQ, got);     check("t6 aw held", got & O_ISO, O_NONE);
    step(REQ | B, got); check("t6 last b", got & (O_ISO | O_ERR), O_NONE);
    step(REQ, got);
    step(REQ, got);     check("t6 iso", got & O_ISO, O_ISO);
    do_reset();
    step(AW | AR, got);
    step(REQ, got);
    step(REQ, got);     check("t6 mid drain", got & O_ISO, O_NONE);
    do_reset();
    step(W, got);       check("t6 w cleared", got & (O_WV | O_WR | O_ISO), O_NONE);
    step(REQ, got);
    step(REQ, got);
    step(REQ, got);     check("t6 counts cleared", got & (O_ISO | O_ACK), O_ISO | O_ACK);

    // random traffic with occasional reset
    do_reset();
    rreq = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 399) do_reset();
      if ($urandom_range(0, 19) == 0) rreq = ~rreq;
      rin = 13'($urandom) & ~REQ;
      if (rreq) rin |= REQ;
      step(rin, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
